// File: rtl/cache_sa_wb_ctrl_pkg.sv
// Shared definitions for the set-associative write-back cache controller.
// Holds the controller state encoding, default geometry and rw encodings.
// Width-dependent structs live in the modules because they follow parameters.
package cache_param_def;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_SETS       = 1024;
  localparam int DEF_WAYS       = 2;
  localparam int DEF_CNT_W      = 32;

  localparam logic CPU_RD   = 1'b0;
  localparam logic CPU_WR   = 1'b1;
  localparam logic MEM_FILL = 1'b0;
  localparam logic MEM_WB   = 1'b1;

endpackage

// File: rtl/cache_way_store.sv
// One cache way: per-set valid/dirty/tag plus line data.
// Ports:
//   clk, rst           clock, async active-high clear of valid/dirty
//   idx                set index for both the read and the write
//   valid/dirty/tag/line  combinational read of set idx
//   line_we            write line_wdata/line_tag, mark valid and clean
//   word_we            write word_wdata into word word_sel, mark dirty
module cache_way_store
  import cache_param_def::*;
#(
  parameter  int SETS       = DEF_SETS,
  parameter  int TAG_W      = 18,
  parameter  int WORD_W     = DEF_WORD_W,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int LINE_W     = LINE_WORDS * WORD_W,
  localparam int INDEX_W    = $clog2(SETS),
  localparam int WSEL_W     = $clog2(LINE_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output logic [LINE_W-1:0]  line,
  input  logic               line_we,
  input  logic [LINE_W-1:0]  line_wdata,
  input  logic [TAG_W-1:0]   line_tag,
  input  logic               word_we,
  input  logic [WSEL_W-1:0]  word_sel,
  input  logic [WORD_W-1:0]  word_wdata
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= line_tag;
      data_mem[idx] <= line_wdata;
    end else if (word_we) begin
      data_mem[idx][word_sel*WORD_W +: WORD_W] <= word_wdata;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_mem[idx];
  assign line  = data_mem[idx];

endmodule

// File: rtl/cache_sa_wb_ctrl.sv
// N-way set-associative, write-back, write-allocate cache controller with
// round-robin replacement and saturating hit/miss counters.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cpu_req_*                      CPU request (sampled in IDLE only)
//   cpu_res_ready/data             one-cycle result strobe and read data
//   mem_req_*                      line fill (rw=0) / write-back (rw=1)
//   mem_res_ready/data             memory done / fill line
//   hit_cnt, miss_cnt              saturating performance counters
module cache_sa_wb_ctrl
  import cache_param_def::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int WORD_W     = DEF_WORD_W,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  parameter  int SETS       = DEF_SETS,
  parameter  int WAYS       = DEF_WAYS,
  parameter  int CNT_W      = DEF_CNT_W,
  localparam int LINE_W     = LINE_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_rw,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [WORD_W-1:0] cpu_req_data,
  output logic              cpu_res_ready,
  output logic [WORD_W-1:0] cpu_res_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_res_ready,
  input  logic [LINE_W-1:0] mem_res_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int INDEX_W  = $clog2(SETS);
  localparam int OFFSET_W = $clog2(LINE_W/8);
  localparam int BYTE_W   = $clog2(WORD_W/8);
  localparam int WSEL_W   = OFFSET_W - BYTE_W;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef struct packed {
    logic               rw;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [WSEL_W-1:0]  wsel;
    logic [WORD_W-1:0]  data;
  } req_t;

  state_t                         state_q, state_d;
  req_t                           req_q;
  logic                           refill_q;
  logic [WAY_W-1:0]               victim_q, victim_d, hit_way, rr_cur;
  tag_entry_t [WAYS-1:0]          ent;
  logic [WAYS-1:0][LINE_W-1:0]    line;
  logic [WAYS-1:0]                hit_vec, way_valid, line_we, word_we;
  logic                           hit, all_valid, rr_adv;
  logic                           unused_byte;

  assign unused_byte = ^cpu_req_addr[BYTE_W-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_store #(
      .SETS(SETS), .TAG_W(TAG_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (req_q.index),
      .valid     (ent[w].valid),
      .dirty     (ent[w].dirty),
      .tag       (ent[w].tag),
      .line      (line[w]),
      .line_we   (line_we[w]),
      .line_wdata(mem_res_data),
      .line_tag  (req_q.tag),
      .word_we   (word_we[w]),
      .word_sel  (req_q.wsel),
      .word_wdata(req_q.data)
    );
    assign way_valid[w] = ent[w].valid;
    assign hit_vec[w]   = ent[w].valid && (ent[w].tag == req_q.tag);
  end

  assign hit       = |hit_vec;
  assign all_valid = &way_valid;
  assign rr_adv    = (state_q == COMPARE) && !hit && all_valid;

  if (WAYS > 1) begin : g_rr
    logic [SETS-1:0][WAY_W-1:0] rr_ptr;
    // WAYS is a power of two, so the natural wrap is the modulo.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         rr_ptr <= '0;
      else if (rr_adv) rr_ptr[req_q.index] <= rr_ptr[req_q.index] + WAY_W'(1);
    end
    assign rr_cur = rr_ptr[req_q.index];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  // Lowest-numbered hit / invalid way wins; scan high to low so low overrides.
  always_comb begin
    hit_way  = '0;
    victim_d = rr_cur;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w])       hit_way  = WAY_W'(w);
      if (!ent[w].valid)    victim_d = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      victim_q <= '0;
      refill_q <= 1'b0;
    end else begin
      if (state_q == IDLE && cpu_req_valid) begin
        req_q.rw    <= cpu_req_rw;
        req_q.tag   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
        req_q.index <= cpu_req_addr[OFFSET_W +: INDEX_W];
        req_q.wsel  <= cpu_req_addr[BYTE_W +: WSEL_W];
        req_q.data  <= cpu_req_data;
      end
      if (state_q == COMPARE && !hit) victim_q <= victim_d;
      // Marks the re-compare after a fill so it is not counted as a hit.
      if (state_q == ALLOCATE && mem_res_ready) refill_q <= 1'b1;
      else if (state_q == COMPARE)              refill_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == COMPARE) begin
      if (hit && !refill_q && hit_cnt != '1) hit_cnt  <= hit_cnt + CNT_W'(1);
      if (!hit && miss_cnt != '1)            miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (cpu_req_valid) state_d = COMPARE;
      COMPARE: begin
        if (hit)                                             state_d = IDLE;
        else if (ent[victim_d].valid && ent[victim_d].dirty) state_d = WRITE_BACK;
        else                                                 state_d = ALLOCATE;
      end
      WRITE_BACK: if (mem_res_ready) state_d = ALLOCATE;
      ALLOCATE:   if (mem_res_ready) state_d = COMPARE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_res_ready = 1'b0;
    cpu_res_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = MEM_FILL;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    line_we       = '0;
    word_we       = '0;
    case (state_q)
      COMPARE: if (hit) begin
        cpu_res_ready = 1'b1;
        if (req_q.rw == CPU_WR) word_we[hit_way] = 1'b1;
        else cpu_res_data = line[hit_way][req_q.wsel*WORD_W +: WORD_W];
      end
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = MEM_WB;
        mem_req_addr  = {ent[victim_q].tag, req_q.index, OFFSET_W'(0)};
        mem_req_data  = line[victim_q];
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = MEM_FILL;
        mem_req_addr  = {req_q.tag, req_q.index, OFFSET_W'(0)};
        if (mem_res_ready) line_we[victim_q] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_sa_wb_ctrl.sv
// Directed bench for cache_sa_wb_ctrl (default geometry, 3-bit counters so
// saturation is reachable). A small memory responder answers each request
// after a chosen latency; expected values are hand-computed constants.
module tb_cache_sa_wb_ctrl;
  localparam int CNT_W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_valid, cpu_req_rw;
  logic [31:0]  cpu_req_addr, cpu_req_data;
  logic         cpu_res_ready;
  logic [31:0]  cpu_res_data;
  logic         mem_req_valid, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_res_ready;
  logic [127:0] mem_res_data;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  cache_sa_wb_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last access
  logic [31:0]  r_data;
  int           r_cyc, r_pulses;
  logic         wb_seen, fill_seen, stable_ok, done;
  logic [31:0]  wb_addr, fill_addr;
  logic [127:0] wb_data;

  // Issue one request and serve memory; r_cyc counts cycles after acceptance.
  task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [127:0] fill, input int lat,
                        input logic inject, input logic [31:0] inj_addr);
    int wcnt, post;
    logic fresh;
    logic [160:0] snap;
    wb_seen = 0; fill_seen = 0; stable_ok = 1; done = 0;
    r_data = '0; r_cyc = 0; r_pulses = 0; wcnt = 0; post = 0; fresh = 1; snap = '0;
    cpu_req_valid = 1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_data = wdata;
    tick();
    cpu_req_valid = 0;
    for (int c = 1; c <= 200 && post < 4; c++) begin
      if (cpu_res_ready) begin
        r_pulses++;
        if (!done) begin r_data = cpu_res_data; r_cyc = c; done = 1; end
      end
      mem_res_ready = 0;
      if (mem_req_valid) begin
        if (fresh) begin
          snap  = {mem_req_rw, mem_req_addr, mem_req_data};
          fresh = 0;
          wcnt  = 0;
          if (mem_req_rw) begin wb_seen = 1; wb_addr = mem_req_addr; wb_data = mem_req_data; end
          else begin fill_seen = 1; fill_addr = mem_req_addr; end
        end else if ({mem_req_rw, mem_req_addr, mem_req_data} !== snap) begin
          stable_ok = 0;
        end
        if (wcnt == lat) begin
          mem_res_ready = 1; mem_res_data = fill; fresh = 1;
        end
        wcnt++;
      end
      cpu_req_valid = inject && mem_req_valid;
      cpu_req_addr  = inject ? inj_addr : addr;
      if (done) post++;
      tick();
    end
    mem_res_ready = 0;
    cpu_req_valid = 0;
    chk("completed", done, 1'b1);
  endtask

  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] F1 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] F2 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] F3 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
  localparam logic [127:0] F4 = 128'h4D4D4D4D_4C4C4C4C_4B4B4B4B_4A4A4A4A;
  localparam logic [127:0] F5 = 128'h5D5D5D5D_5C5C5C5C_5B5B5B5B_5A5A5A5A;
  localparam logic [127:0] F6 = 128'h6D6D6D6D_6C6C6C6C_6B6B6B6B_6A6A6A6A;

  initial begin
    rst = 1; cpu_req_valid = 0; cpu_req_rw = 0; cpu_req_addr = '0; cpu_req_data = '0;
    mem_res_ready = 0; mem_res_data = '0;
    tick(); tick();
    chk("rst_mem_vld",  mem_req_valid, 1'b0);
    chk("rst_res_rdy",  cpu_res_ready, 1'b0);
    chk("rst_res_data", cpu_res_data, 32'h0);
    chk("rst_mem_addr", mem_req_addr, 32'h0);
    chk("rst_hit_cnt",  hit_cnt, 3'd0);
    chk("rst_miss_cnt", miss_cnt, 3'd0);
    rst = 0;
    tick();

    // read miss into empty cache
    access(0, 32'h10, 0, L1, 0, 0, 0);
    chk("t1_fill",      fill_seen, 1'b1);
    chk("t1_no_wb",     wb_seen, 1'b0);
    chk("t1_fill_addr", fill_addr, 32'h10);
    chk("t1_data",      r_data, 32'h11111111);
    chk("t1_lat",       r_cyc, 3);
    chk("t1_miss",      miss_cnt, 3'd1);
    chk("t1_hit",       hit_cnt, 3'd0);

    // read hit on word 1
    access(0, 32'h14, 0, L1, 0, 0, 0);
    chk("t2_lat",  r_cyc, 1);
    chk("t2_data", r_data, 32'h22222222);
    chk("t2_hit",  hit_cnt, 3'd1);
    chk("t2_nofill", fill_seen, 1'b0);

    // write miss fills the free way
    access(1, 32'h4010, 32'hDEADBEEF, F1, 0, 0, 0);
    chk("t3a_fill_addr", fill_addr, 32'h4010);
    chk("t3a_no_wb",     wb_seen, 1'b0);
    chk("t3a_lat",       r_cyc, 3);
    // set full: round robin picks clean way 0
    access(1, 32'h8010, 32'h12345678, F2, 0, 0, 0);
    chk("t3b_no_wb",     wb_seen, 1'b0);
    chk("t3b_fill_addr", fill_addr, 32'h8010);
    // next victim is dirty way 1 -> write-back first
    access(0, 32'hC010, 0, F3, 0, 0, 0);
    chk("t3c_wb",        wb_seen, 1'b1);
    chk("t3c_wb_addr",   wb_addr, 32'h4010);
    chk("t3c_wb_data",   wb_data, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_DEADBEEF);
    chk("t3c_fill_addr", fill_addr, 32'hC010);
    chk("t3c_data",      r_data, 32'hC0C0C0C0);
    chk("t3c_lat",       r_cyc, 4);
    chk("t3c_miss",      miss_cnt, 3'd4);
    chk("t3c_hit",       hit_cnt, 3'd1);
    // written word survives in way 0
    access(0, 32'h8010, 0, '0, 0, 0, 0);
    chk("t3d_lat",  r_cyc, 1);
    chk("t3d_data", r_data, 32'h12345678);
    chk("t3d_hit",  hit_cnt, 3'd2);

    // slow memory: request stable for 5 waiting cycles
    access(0, 32'h38, 0, F4, 5, 0, 0);
    chk("t4_stable",    stable_ok, 1'b1);
    chk("t4_fill_addr", fill_addr, 32'h30);
    chk("t4_lat",       r_cyc, 8);
    chk("t4_data",      r_data, 32'h4C4C4C4C);
    chk("t4_miss",      miss_cnt, 3'd5);

    // new request during a miss is ignored
    access(0, 32'h20, 0, F5, 2, 1, 32'h10);
    chk("t5_pulses",    r_pulses, 1);
    chk("t5_fill_addr", fill_addr, 32'h20);
    chk("t5_data",      r_data, 32'h5A5A5A5A);
    chk("t5_lat",       r_cyc, 5);
    chk("t5_miss",      miss_cnt, 3'd6);

    // counters saturate
    for (int i = 0; i < 6; i++) access(0, 32'h8010, 0, '0, 0, 0, 0);
    chk("sat_hit", hit_cnt, 3'd7);
    access(0, 32'h40, 0, F4, 0, 0, 0);
    access(0, 32'h50, 0, F4, 0, 0, 0);
    chk("sat_miss", miss_cnt, 3'd7);

    // reset during ALLOCATE, together with mem_res_ready
    cpu_req_valid = 1; cpu_req_rw = 0; cpu_req_addr = 32'h60;
    tick();
    cpu_req_valid = 0;
    tick();
    chk("t6_alloc_vld", mem_req_valid, 1'b1);
    tick();
    mem_res_ready = 1; mem_res_data = F6;
    #2 rst = 1;
    #1;
    chk("t6_rst_vld",  mem_req_valid, 1'b0);
    chk("t6_rst_rdy",  cpu_res_ready, 1'b0);
    chk("t6_rst_hit",  hit_cnt, 3'd0);
    chk("t6_rst_miss", miss_cnt, 3'd0);
    tick();
    mem_res_ready = 0; rst = 0;
    tick();
    access(0, 32'h60, 0, F6, 0, 0, 0);
    chk("t6_60_miss", fill_seen, 1'b1);
    access(0, 32'h14, 0, L1, 0, 0, 0);
    chk("t6_14_miss", fill_seen, 1'b1);
    chk("t6_14_data", r_data, 32'h22222222);
    chk("t6_miss",    miss_cnt, 3'd2);
    chk("t6_hit",     hit_cnt, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_sa_wb_ctrl.md
Name: cache_sa_wb_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller. It generalises the direct-mapped cache_def geometry, where tag, index and line width are set by parameters. It adds round-robin replacement and saturating hit/miss counters. It sits between the CPU request/result interface and the line-wide memory request/response interface.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, CPU data word width
LINE_WORDS, 4, words per line (power of 2); LINE_W = LINE_WORDS*WORD_W
SETS, 1024, sets (power of 2); INDEX_W = log2(SETS)
WAYS, 2, associativity (1, 2 or 4); derived OFFSET_W = log2(LINE_W/8), TAG_W = ADDR_W-INDEX_W-OFFSET_W
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_req_valid  in  1  request valid
cpu_req_rw  in  1  0 = read, 1 = write
cpu_req_addr  in  ADDR_W  byte address
cpu_req_data  in  WORD_W  write data
cpu_res_ready  out  1  one-cycle result strobe
cpu_res_data  out  WORD_W  read data, valid with cpu_res_ready
mem_req_valid  out  1  memory request valid
mem_req_rw  out  1  0 = line fill, 1 = line write-back
mem_req_addr  out  ADDR_W  line-aligned byte address
mem_req_data  out  LINE_W  write-back line
mem_res_ready  in  1  memory done / fill data valid
mem_res_data  in  LINE_W  fill line
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (async, rst=1): state IDLE; all valid/dirty bits 0; rr_ptr[set] = 0; counters 0; every output 0.
- Address split: tag = addr[ADDR_W-1 -: TAG_W]; index = next INDEX_W bits; word select = addr[OFFSET_W-1 : log2(WORD_W/8)]. Byte-offset bits are ignored, so accesses are word-aligned.
- IDLE: when cpu_req_valid=1 at a clock edge, latch rw/addr/data into a request register and go to COMPARE. cpu_req_valid is ignored in every other state; the CPU need not hold it.
- COMPARE: compare all ways in parallel; hit = valid && tag match.
  - Read hit: cpu_res_ready=1 combinationally this cycle, cpu_res_data = selected word.
  - Write hit: update the word, set dirty, cpu_res_ready=1.
  - On any hit, go to IDLE. Hit latency is 1 cycle after acceptance.
  - hit_cnt increments on a hit, unless the refill flag is set (hit that follows a refill). The refill flag is cleared on leaving COMPARE.
  - Miss: miss_cnt increments. Victim = lowest-numbered invalid way; if all ways are valid, victim = rr_ptr[index], then rr_ptr[index] increments modulo WAYS. If the victim is valid and dirty, go to WRITE_BACK, else ALLOCATE.
- WRITE_BACK:
  - mem_req_valid=1, rw=1, addr = {victim tag, index, 0}, data = victim line.
  - On mem_res_ready, go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid=1, rw=0, addr = {req tag, index, 0}.
  - On mem_res_ready: write mem_res_data into the victim way, valid=1, dirty=0, tag=req tag; set the refill flag; go to COMPARE, which now hits.
  - Miss latency = memory latency(s) + 2 cycles.
- mem_req_* outputs are stable while mem_req_valid=1 and mem_res_ready=0. mem_res_ready in IDLE or COMPARE is ignored.
- Counters saturate at all-ones and never wrap.
- WAYS=1 degenerates to direct-mapped: victim = way 0, no rr_ptr storage.
- Reset mid-operation: mem_req_valid and cpu_res_ready drop immediately (asynchronously). The pending request is discarded and all lines are invalidated. Dirty data is lost by design.
- Simultaneous mem_res_ready and rst: rst wins.

Decomposition:
- Package cache_param_def: state enum (IDLE, COMPARE, WRITE_BACK, ALLOCATE), default geometry constants, rw encodings.
- Width-dependent struct typedefs (tag entry, request register) are local to the module because they depend on parameters.
- Sub-module cache_way_store: one way's valid/dirty/tag/data arrays. Combinational read by index; synchronous line write and word write; async clear of valid/dirty. Instantiated WAYS times.

Test Plan:
(Defaults throughout: index = addr[13:4], tag = addr[31:14].)
1. After reset, read 0x0000_0010 → miss, no write-back; fill request addr 0x10 rw=0. Respond with line 0x44444444_33333333_22222222_11111111 → cpu_res_data 0x11111111, miss_cnt 1, hit_cnt 0.
2. Then read 0x0000_0014 → cpu_res_ready on the cycle after acceptance, data 0x22222222, hit_cnt 1.
3. Write 0x0000_4010 data 0xDEADBEEF → miss fills way1 (addr 0x4010), no write-back. Then write 0x0000_8010 → victim way0 (rr_ptr 0, clean), fill only. Then read 0x0000_C010 → victim way1 (dirty): WRITE_BACK addr 0x4010 with word0 0xDEADBEEF, then ALLOCATE addr 0xC010.
4. Hold mem_res_ready low for 5 cycles in ALLOCATE → mem_req_valid/addr/rw stay constant; completion 1 cycle after mem_res_ready.
5. Assert cpu_req_valid with a different address during a miss → ignored. Only the original request completes, and exactly one cpu_res_ready pulse occurs.
6. Assert rst during ALLOCATE → mem_req_valid=0 immediately. Re-reading 0x0000_0014 then misses; counters restart from 0.
